gpio_word_bus_ctrl: RTL

- Bus master that turns 32-bit host read/write requests into a sequence of byte-wide accesses on the 8-bit peripheral bus used by the GPIO block.
- Drives the bus signals cs, rd, wr, addr and write data, waits for ready, and assembles read data.
- Adds byte enables, a ready timeout with error reporting, and a one-cycle ack handshake toward the host.

---
 rtl/gpio_word_bus_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gpio_word_bus_ctrl.sv
// gpio_word_bus_ctrl: 32-bit host word access to byte-wide GPIO bus.
// Walks enabled byte lanes as SETUP/STROBE/GAP with ready timeout.
module gpio_word_bus_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic              p_cs,
    output logic              p_rd,
    output logic              p_wr,
    output logic [ADDR_W-1:0] p_addr,
    output logic [7:0]        p_wdata,
    input  logic [7:0]        p_rdata,
    input  logic              p_ready
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]        state;
    logic              we_q;
    logic [ADDR_W-1:0] base_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [1:0]        idx;
    logic [TW-1:0]     tcnt;

    logic              first_v;
    logic [1:0]        first_k;
    logic              next_v;
    logic [1:0]        next_k;

    // Lowest enabled lane of the incoming request.
    always_comb begin
        first_v = 1'b0;
        first_k = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (be[j]) begin
                first_v = 1'b1;
                first_k = 2'(j);
            end
        end
    end

    // Lowest enabled lane above the one just finished.
    always_comb begin
        next_v = 1'b0;
        next_k = 2'd0;
        for (int j = 3; j >= 0; j--) begin
            if (be_q[j] && (2'(j) > idx)) begin
                next_v = 1'b1;
                next_k = 2'(j);
            end
        end
    end

    // Bus strobes and host status decode straight from the state.
    always_comb begin
        p_cs = (state == STROBE);
        p_rd = p_cs & ~we_q;
        p_wr = p_cs & we_q;
        ack  = (state == DONE);
        busy = (state != IDLE);
    end

    // Transfer sequencer, lane bookkeeping and ready timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            base_q  <= '0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            idx     <= 2'd0;
            tcnt    <= '0;
            rdata   <= 32'd0;
            err     <= 1'b0;
            p_addr  <= '0;
            p_wdata <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        base_q  <= {haddr[ADDR_W-1:2], 2'b00};
                        be_q    <= be;
                        wdata_q <= wdata;
                        rdata   <= 32'd0;
                        err     <= 1'b0;
                        tcnt    <= '0;
                        if (first_v) begin
                            idx     <= first_k;
                            p_addr  <= {haddr[ADDR_W-1:2], first_k};
                            p_wdata <= we ? wdata[{first_k, 3'b000} +: 8]
                                          : 8'd0;
                            state   <= SETUP;
                        end else begin
                            idx   <= 2'd0;
                            state <= DONE;
                        end
                    end
                end
                SETUP: begin
                    state <= STROBE;
                end
                STROBE: begin
                    if (p_ready) begin
                        if (!we_q) begin
                            rdata[{idx, 3'b000} +: 8] <= p_rdata;
                        end
                        tcnt  <= '0;
                        state <= GAP;
                    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        err   <= 1'b1;
                        tcnt  <= '0;
                        state <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                GAP: begin
                    tcnt <= '0;
                    if (next_v) begin
                        idx     <= next_k;
                        p_addr  <= {base_q[ADDR_W-1:2], next_k};
                        p_wdata <= we_q ? wdata_q[{next_k, 3'b000} +: 8]
                                        : 8'd0;
                        state   <= SETUP;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    idx   <= 2'd0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
